// File: rtl/lc3_mem_pkg.sv
// Shared address map and types for the LC-3 memory/console subsystem.
package lc3_mem_pkg;

  typedef logic [15:0] word_t;

  localparam word_t IO_BASE_DEFAULT = 16'hFE00;
  localparam word_t KBSR_ADDR       = 16'hFE00;
  localparam word_t KBDR_ADDR       = 16'hFE02;
  localparam word_t DSR_ADDR        = 16'hFE04;
  localparam word_t DDR_ADDR        = 16'hFE06;
  localparam word_t MCR_ADDR        = 16'hFFFE;

  localparam int READY_BIT = 15;

endpackage

// File: rtl/lc3_memory_io_if.sv
// Processor bus, backdoor load port and console handshakes of the LC-3 memory subsystem.
interface lc3_memory_io_if;
  import lc3_mem_pkg::*;

  logic        writeEnable;
  word_t       address;
  word_t       dataToMemory;
  word_t       dataFromMemory;
  logic        load_en;
  word_t       load_addr;
  word_t       load_data;
  logic        kbd_valid;
  logic [7:0]  kbd_data;
  logic        kbd_ready;
  logic        dsp_valid;
  logic [7:0]  dsp_data;
  logic        dsp_ready;
  logic        halt;

  modport master (
    output writeEnable, address, dataToMemory, load_en, load_addr, load_data,
    output kbd_valid, kbd_data, dsp_ready,
    input  dataFromMemory, kbd_ready, dsp_valid, dsp_data, halt
  );

  modport slave (
    input  writeEnable, address, dataToMemory, load_en, load_addr, load_data,
    input  kbd_valid, kbd_data, dsp_ready,
    output dataFromMemory, kbd_ready, dsp_valid, dsp_data, halt
  );

endinterface

// File: rtl/lc3_console_regs.sv
// Console registers (KBSR/KBDR/DSR/DDR/MCR); combinational read, writes at posedge.
// Keyboard accepts only while empty; display holds one character until dsp_ready.
module lc3_console_regs
  import lc3_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  word_t      address,
  input  logic       cpu_we,
  input  logic       wr_block,
  input  logic       wdata_run,
  input  logic [7:0] wdata_chr,
  input  logic       kbd_valid,
  input  logic [7:0] kbd_data,
  output logic       kbd_ready,
  output logic       dsp_valid,
  output logic [7:0] dsp_data,
  input  logic       dsp_ready,
  output logic       halt,
  output word_t      io_rdata,
  output logic       io_hit
);

  logic       kbd_full_q, kbd_full_d;
  logic [7:0] kbd_char_q, kbd_char_d;
  logic       dsp_empty_q, dsp_empty_d;
  logic       dsp_valid_q, dsp_valid_d;
  logic [7:0] dsp_data_q, dsp_data_d;
  logic       mcr_run_q, mcr_run_d;
  logic       halt_q, halt_d;
  logic       kbdr_hit_q, kbdr_hit_d;
  logic       wr_en;
  logic       kbdr_match;

  always_comb begin
    kbd_full_d  = kbd_full_q;
    kbd_char_d  = kbd_char_q;
    dsp_empty_d = dsp_empty_q;
    dsp_valid_d = dsp_valid_q;
    dsp_data_d  = dsp_data_q;
    mcr_run_d   = mcr_run_q;

    wr_en      = cpu_we && !wr_block;
    kbdr_match = (address == KBDR_ADDR);
    kbdr_hit_d = kbdr_match;

    // Only the first cycle of a KBDR read consumes the character.
    if (kbd_valid && !kbd_full_q) begin
      kbd_char_d = kbd_data;
      kbd_full_d = 1'b1;
    end else if (kbdr_match && !cpu_we && !kbdr_hit_q) begin
      kbd_full_d = 1'b0;
    end

    if (dsp_valid_q && dsp_ready) begin
      dsp_valid_d = 1'b0;
      dsp_empty_d = 1'b1;
    end
    // Uses the registered empty flag, so a write racing a drain is dropped.
    if (wr_en && (address == DDR_ADDR) && dsp_empty_q) begin
      dsp_data_d  = wdata_chr;
      dsp_empty_d = 1'b0;
      dsp_valid_d = 1'b1;
    end

    if (wr_en && (address == MCR_ADDR)) begin
      mcr_run_d = wdata_run;
    end
    halt_d = !mcr_run_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kbd_full_q  <= 1'b0;
      kbd_char_q  <= 8'h00;
      dsp_empty_q <= 1'b1;
      dsp_valid_q <= 1'b0;
      dsp_data_q  <= 8'h00;
      mcr_run_q   <= 1'b1;
      halt_q      <= 1'b0;
      kbdr_hit_q  <= 1'b0;
    end else begin
      kbd_full_q  <= kbd_full_d;
      kbd_char_q  <= kbd_char_d;
      dsp_empty_q <= dsp_empty_d;
      dsp_valid_q <= dsp_valid_d;
      dsp_data_q  <= dsp_data_d;
      mcr_run_q   <= mcr_run_d;
      halt_q      <= halt_d;
      kbdr_hit_q  <= kbdr_hit_d;
    end
  end

  always_comb begin
    io_rdata = '0;
    io_hit   = 1'b1;
    case (address)
      KBSR_ADDR: io_rdata[READY_BIT] = kbd_full_q;
      KBDR_ADDR: io_rdata[7:0]       = kbd_char_q;
      DSR_ADDR:  io_rdata[READY_BIT] = dsp_empty_q;
      DDR_ADDR:  io_rdata[7:0]       = dsp_data_q;
      MCR_ADDR:  io_rdata[READY_BIT] = mcr_run_q;
      default:   io_hit              = 1'b0;
    endcase
  end

  assign kbd_ready = !kbd_full_q;
  assign dsp_valid = dsp_valid_q;
  assign dsp_data  = dsp_data_q;
  assign halt      = halt_q;

endmodule

// File: rtl/lc3_memory_io.sv
// LC-3 word RAM plus memory-mapped console; reads are zero-latency, writes land at posedge.
// Backdoor load wins over the processor write in the same cycle; RAM is never reset.
module lc3_memory_io
  import lc3_mem_pkg::*;
#(
  parameter int    ADDR_BITS = 12,
  parameter word_t IO_BASE   = IO_BASE_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  lc3_memory_io_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  word_t                 ram_q [DEPTH];
  logic                  ram_we_d;
  logic [ADDR_BITS-1:0]  ram_idx_d;
  word_t                 ram_wdata_d;
  word_t                 io_rdata;
  logic                  io_hit;

  always_comb begin
    ram_we_d    = 1'b0;
    ram_idx_d   = bus.address[ADDR_BITS-1:0];
    ram_wdata_d = bus.dataToMemory;
    if (bus.load_en) begin
      ram_we_d    = (bus.load_addr < IO_BASE);
      ram_idx_d   = bus.load_addr[ADDR_BITS-1:0];
      ram_wdata_d = bus.load_data;
    end else if (bus.writeEnable) begin
      ram_we_d = (bus.address < IO_BASE);
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we_d) begin
      ram_q[ram_idx_d] <= ram_wdata_d;
    end
  end

  lc3_console_regs u_console (
    .clk       (clk),
    .rst_n     (reset),
    .address   (bus.address),
    .cpu_we    (bus.writeEnable),
    .wr_block  (bus.load_en),
    .wdata_run (bus.dataToMemory[READY_BIT]),
    .wdata_chr (bus.dataToMemory[7:0]),
    .kbd_valid (bus.kbd_valid),
    .kbd_data  (bus.kbd_data),
    .kbd_ready (bus.kbd_ready),
    .dsp_valid (bus.dsp_valid),
    .dsp_data  (bus.dsp_data),
    .dsp_ready (bus.dsp_ready),
    .halt      (bus.halt),
    .io_rdata  (io_rdata),
    .io_hit    (io_hit)
  );

  // Unmapped I/O addresses fall through to zero from the console mux.
  always_comb begin
    if (bus.address >= IO_BASE) begin
      bus.dataFromMemory = io_hit ? io_rdata : 16'h0000;
    end else begin
      bus.dataFromMemory = ram_q[bus.address[ADDR_BITS-1:0]];
    end
  end

endmodule

// File: tb/tb_lc3_memory_io.sv
// Directed bench for lc3_memory_io: RAM, backdoor priority, keyboard, display, MCR and reset.
module tb_lc3_memory_io;
  import lc3_mem_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  lc3_memory_io_if bus ();

  lc3_memory_io #(.ADDR_BITS(12), .IO_BASE(16'hFE00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    bus.address = a;
    #1;
    check_eq(tag, bus.dataFromMemory, exp);
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d);
    bus.address      = a;
    bus.dataToMemory = d;
    bus.writeEnable  = 1'b1;
    tick();
    bus.writeEnable  = 1'b0;
    bus.address      = 16'h0000;
  endtask

  task automatic bd_wr(input logic [15:0] a, input logic [15:0] d);
    bus.load_addr = a;
    bus.load_data = d;
    bus.load_en   = 1'b1;
    tick();
    bus.load_en   = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset            = 1'b0;
    bus.writeEnable  = 1'b0;
    bus.address      = 16'h0000;
    bus.dataToMemory = 16'h0000;
    bus.load_en      = 1'b0;
    bus.load_addr    = 16'h0000;
    bus.load_data    = 16'h0000;
    bus.kbd_valid    = 1'b0;
    bus.kbd_data     = 8'h00;
    bus.dsp_ready    = 1'b0;
    #3;
    check_eq("rst_kbd_ready", 16'(bus.kbd_ready), 16'h1);
    check_eq("rst_dsp_valid", 16'(bus.dsp_valid), 16'h0);
    check_eq("rst_dsp_data",  16'(bus.dsp_data),  16'h0);
    check_eq("rst_halt",      16'(bus.halt),      16'h0);

    // Preload while the console is still in reset.
    bd_wr(16'h0010, 16'h1234);
    bd_wr(16'h0020, 16'hAAAA);
    #2 reset = 1'b1;
    tick();

    rd("ram_rd_0010", 16'h0010, 16'h1234);
    rd("ram_wrap_1010", 16'h1010, 16'h1234);

    // Processor write and backdoor load in the same cycle.
    bus.address      = 16'h0020;
    bus.dataToMemory = 16'hBEEF;
    bus.writeEnable  = 1'b1;
    bus.load_addr    = 16'h0030;
    bus.load_data    = 16'h0001;
    bus.load_en      = 1'b1;
    tick();
    bus.writeEnable = 1'b0;
    bus.load_en     = 1'b0;
    rd("bd_prio_0030", 16'h0030, 16'h0001);
    rd("cpu_suppr_0020", 16'h0020, 16'hAAAA);

    cpu_wr(16'h0040, 16'h5A5A);
    rd("cpu_wr_0040", 16'h0040, 16'h5A5A);

    // Keyboard handshake.
    bus.address   = 16'h0000;
    bus.kbd_valid = 1'b1;
    bus.kbd_data  = 8'h41;
    #1;
    check_eq("kbd_ready_empty", 16'(bus.kbd_ready), 16'h1);
    tick();
    bus.kbd_valid = 1'b0;
    check_eq("kbd_ready_full", 16'(bus.kbd_ready), 16'h0);
    rd("kbsr_full", 16'hFE00, 16'h8000);

    // Hold KBDR for three cycles; second key arrives mid-hold.
    rd("kbdr_c1", 16'hFE02, 16'h0041);
    tick();
    check_eq("kbdr_c1_ready", 16'(bus.kbd_ready), 16'h1);
    check_eq("kbdr_c2", bus.dataFromMemory, 16'h0041);
    bus.kbd_valid = 1'b1;
    bus.kbd_data  = 8'h42;
    tick();
    bus.kbd_valid = 1'b0;
    check_eq("kbdr_c3", bus.dataFromMemory, 16'h0042);
    check_eq("kbd_2nd_full", 16'(bus.kbd_ready), 16'h0);
    tick();
    check_eq("kbd_no_reclear", 16'(bus.kbd_ready), 16'h0);
    rd("kbsr_2nd", 16'hFE00, 16'h8000);

    // KBSR is read-only.
    cpu_wr(16'hFE00, 16'h0000);
    rd("kbsr_ro", 16'hFE00, 16'h8000);

    // Display.
    cpu_wr(16'hFE06, 16'h0058);
    check_eq("dsp_valid_set", 16'(bus.dsp_valid), 16'h1);
    check_eq("dsp_data_58",   16'(bus.dsp_data),  16'h0058);
    rd("dsr_busy", 16'hFE04, 16'h0000);
    rd("ddr_rd", 16'hFE06, 16'h0058);
    cpu_wr(16'hFE06, 16'h0059);
    check_eq("ddr_drop", 16'(bus.dsp_data), 16'h0058);
    bus.dsp_ready = 1'b1;
    tick();
    bus.dsp_ready = 1'b0;
    check_eq("dsp_drained", 16'(bus.dsp_valid), 16'h0);
    rd("dsr_empty", 16'hFE04, 16'h8000);

    // Write racing a drain is dropped.
    cpu_wr(16'hFE06, 16'h0060);
    bus.dsp_ready = 1'b1;
    cpu_wr(16'hFE06, 16'h0061);
    bus.dsp_ready = 1'b0;
    check_eq("race_valid", 16'(bus.dsp_valid), 16'h0);
    check_eq("race_data",  16'(bus.dsp_data),  16'h0060);

    // MCR and halt.
    cpu_wr(16'hFFFE, 16'h0000);
    check_eq("halt_set", 16'(bus.halt), 16'h1);
    rd("mcr_clr", 16'hFFFE, 16'h0000);
    cpu_wr(16'hFFFE, 16'h8000);
    check_eq("halt_clr", 16'(bus.halt), 16'h0);
    rd("mcr_set", 16'hFFFE, 16'h8000);
    rd("unmapped_io", 16'hFE08, 16'h0000);

    // Backdoor load suppresses an I/O write too.
    bus.address      = 16'hFFFE;
    bus.dataToMemory = 16'h0000;
    bus.writeEnable  = 1'b1;
    bus.load_addr    = 16'h0050;
    bus.load_data    = 16'h7777;
    bus.load_en      = 1'b1;
    tick();
    bus.writeEnable = 1'b0;
    bus.load_en     = 1'b0;
    check_eq("bd_suppr_mcr", 16'(bus.halt), 16'h0);
    rd("bd_0050", 16'h0050, 16'h7777);

    // Asynchronous reset with a pending display char and unread key.
    cpu_wr(16'hFE06, 16'h0070);
    cpu_wr(16'hFFFE, 16'h0000);
    check_eq("pre_rst_valid", 16'(bus.dsp_valid), 16'h1);
    check_eq("pre_rst_halt",  16'(bus.halt),      16'h1);
    check_eq("pre_rst_kbd",   16'(bus.kbd_ready), 16'h0);
    #2 reset = 1'b0;
    #1;
    check_eq("arst_kbd_ready", 16'(bus.kbd_ready), 16'h1);
    check_eq("arst_dsp_valid", 16'(bus.dsp_valid), 16'h0);
    check_eq("arst_dsp_data",  16'(bus.dsp_data),  16'h0);
    check_eq("arst_halt",      16'(bus.halt),      16'h0);
    rd("arst_kbdr", 16'hFE02, 16'h0000);
    rd("arst_dsr", 16'hFE04, 16'h8000);
    #1 reset = 1'b1;
    tick();
    rd("ram_survives", 16'h0010, 16'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_memory_io.md
Name: lc3_memory_io

Overview:
- Memory subsystem sitting directly downstream of the LC-3 processor core, on its writeEnable/address/dataToMemory/dataFromMemory bus.
- Provides a word-addressed RAM with asynchronous read.
- Memory-maps the console registers at the top of the address space: KBSR, KBDR, DSR, DDR and MCR.
- Provides a backdoor load port so benches can preload programs.

Parameters:
- ADDR_BITS, 12, RAM depth is 2**ADDR_BITS 16-bit words.
- IO_BASE, 16'hFE00, start of the I/O region; addresses at or above it never reach RAM.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- writeEnable  in  1  processor write strobe, sampled at posedge.
- address  in  16  processor word address.
- dataToMemory  in  16  processor write data.
- dataFromMemory  out  16  read data, combinational from address.
- load_en  in  1  backdoor RAM write enable.
- load_addr  in  16  backdoor address.
- load_data  in  16  backdoor data.
- kbd_valid  in  1  keyboard character offered.
- kbd_data  in  8  keyboard character.
- kbd_ready  out  1  keyboard character accepted when kbd_valid && kbd_ready.
- dsp_valid  out  1  display character pending.
- dsp_data  out  8  display character.
- dsp_ready  in  1  display consumes the character when dsp_valid && dsp_ready.
- halt  out  1  MCR[15] cleared by software.

Behaviour:
- Address map:
  - RAM: address < IO_BASE; index = address[ADDR_BITS-1:0], so RAM wraps modulo depth.
  - KBSR FE00, KBDR FE02, DSR FE04, DDR FE06, MCR FFFE.
  - Any other I/O address reads 16'h0000; writes to it are ignored.
- Reads: dataFromMemory is a pure combinational function of address and current state, with no latency. The core captures it one cycle after driving address.
  - KBSR reads {kbd_full,15'b0}.
  - KBDR reads {8'b0,kbd_char}.
  - DSR reads {dsp_empty,15'b0}.
  - DDR reads {8'b0,dsp_data}.
  - MCR reads {mcr_run,15'b0}.
- Writes: on posedge with writeEnable=1, exactly one write per cycle.
  - RAM word updated.
  - MCR write: mcr_run <= dataToMemory[15].
  - DDR write, only when dsp_empty=1: dsp_data <= dataToMemory[7:0], dsp_empty <= 0, dsp_valid <= 1.
  - DDR write while dsp_empty=0: silently dropped.
  - KBSR, KBDR and DSR are read-only; writes to them are ignored.
- Backdoor load: load_en=1 writes load_data to RAM[load_addr[ADDR_BITS-1:0]] and has priority.
  - The processor write in the same cycle is suppressed entirely, RAM and I/O alike.
  - load_addr >= IO_BASE is ignored.
- Keyboard:
  - kbd_ready = ~kbd_full.
  - On handshake: kbd_char <= kbd_data, kbd_full <= 1.
  - Read-clear: kbd_full <= 0 on the first cycle address==KBDR with writeEnable=0.
  - "First cycle" means address matches KBDR and the registered match flag kbdr_hit_q was 0.
  - Holding the address for multiple cycles clears only once. A character arriving afterwards is not lost.
  - Read-clear and handshake cannot coincide because kbd_ready=0 while full.
- Display:
  - On dsp_valid && dsp_ready: dsp_valid <= 0, dsp_empty <= 1.
  - A DDR write in that same cycle sees dsp_empty=0 and is dropped.
- halt = ~mcr_run, registered.
- Reset values (asynchronous, while reset=0):
  - Outputs: kbd_ready 1, dsp_valid 0, dsp_data 0, halt 0.
  - Internal state: kbd_full 0, kbd_char 0, dsp_empty 1, mcr_run 1, kbdr_hit_q 0.
  - RAM contents are not cleared.
  - Reset mid-transfer drops a pending display character and discards an unread keyboard character.
- Core reset and memory reset are independent. RAM preloaded under reset survives.

Decomposition:
- Package lc3_mem_pkg holds:
  - Address constants KBSR_ADDR, KBDR_ADDR, DSR_ADDR, DDR_ADDR, MCR_ADDR, IO_BASE_DEFAULT.
  - Bit-position constant READY_BIT=15.
  - Typedef word_t (logic [15:0]).
- One sub-module lc3_console_regs contains:
  - Keyboard/display/MCR state, handshakes and read-clear logic.
  - Outputs: I/O read data and a hit flag.
- The top level holds the RAM array, the address decode and the read mux.

Test Plan:
- Backdoor load 16'h1234 to 0x0010, then drive address=0x0010 -> dataFromMemory=16'h1234 the same cycle. Address 0x1010 (wrap, ADDR_BITS=12) also reads 16'h1234.
- Processor writes 16'hBEEF to 0x0020 with writeEnable high one cycle, and in the same cycle load_en writes 16'h0001 to 0x0030 -> 0x0030=16'h0001, 0x0020 unchanged.
- kbd_valid=1, kbd_data=8'h41 -> kbd_ready drops next cycle, KBSR reads 16'h8000.
  - Hold address=FE02 for 3 cycles -> reads 16'h0041, KBSR=0 after the first cycle.
  - A second key 8'h42 offered during the hold is accepted and KBSR returns to 8000.
- Write DDR=16'h0058 with dsp_ready=0 -> dsp_valid=1, dsp_data=8'h58, DSR=0.
  - A second DDR write of 16'h0059 is dropped.
  - Pulse dsp_ready -> dsp_valid=0, DSR=16'h8000.
- Write MCR=16'h0000 -> halt=1 next cycle; MCR reads 0. Write 16'h8000 -> halt=0.
- Assert reset low asynchronously with dsp_valid=1 and kbd_full=1 -> all outputs take their reset values immediately; RAM word at 0x0010 is still 16'h1234 after reset release.
